// File: rtl/sample_window_pkg.sv
// Shared types and constants for the sample window loader.
// Optional feature macro: SLIDING_WINDOW_EN (see sample_window_loader.sv).
package sample_window_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int N_TAPS         = 8;

  // Fill counter values (4 bits covers 0..8)
  localparam logic [3:0] FILL_FULL    = 4'd8;
  localparam logic [3:0] REFILL_BLOCK = 4'd0;
  localparam logic [3:0] REFILL_SLIDE = 4'd7;

  typedef enum logic {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/sample_window_loader_shift_reg.sv
// sample_shift_reg: N_TAPS x DATA_W shift register. Tap 0 (lowest slice)
// is the oldest sample; new samples enter at the top slice.
module sample_shift_reg
  import sample_window_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic [DATA_W-1:0]        d,
  output logic [N_TAPS*DATA_W-1:0] taps
);

  // Shift one position toward tap 0 when enabled; clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      taps <= '0;
    end else if (shift_en) begin
      taps <= {d, taps[N_TAPS*DATA_W-1:DATA_W]};
    end else begin
      taps <= taps;
    end
  end

endmodule

// File: rtl/sample_window_loader.sv
// sample_window_loader: assembles a serial sample stream into an 8-wide
// window x0 (oldest) .. x7 (newest) with valid/ready handshakes on both sides.
// Optional feature macro: SLIDING_WINDOW_EN. When defined, a consumed window
// keeps 7 taps so every new sample yields a new window; otherwise windows are
// disjoint blocks of 8 samples.
// Note for integrators: in PRESENT, s_ready follows win_ready combinationally.
module sample_window_loader
  import sample_window_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] x0,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] x3,
  output logic [DATA_W-1:0] x4,
  output logic [DATA_W-1:0] x5,
  output logic [DATA_W-1:0] x6,
  output logic [DATA_W-1:0] x7,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [7:0]        win_seq
);

`ifdef SLIDING_WINDOW_EN
  localparam logic [3:0] REFILL = REFILL_SLIDE;
`else
  localparam logic [3:0] REFILL = REFILL_BLOCK;
`endif
  localparam logic [3:0] REFILL_PLUS1 = REFILL + 4'd1;

  state_t                     state_r;
  state_t                     state_nxt_s;
  logic [3:0]                 fill_cnt_r;
  logic [3:0]                 fill_cnt_nxt_s;
  logic [7:0]                 win_seq_r;
  logic                       accept_s;
  logic                       consume_s;
  logic                       shift_en_s;
  logic                       seq_inc_s;
  logic [N_TAPS*DATA_W-1:0]   taps_s;

  sample_shift_reg #(
    .DATA_W(DATA_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en_s),
    .d        (s_data),
    .taps     (taps_s)
  );

  // Handshake qualification: ready is held low through reset
  always_comb begin
    s_ready = 1'b0;
    if (rst) begin
      s_ready = 1'b0;
    end else begin
      case (state_r)
        FILL:    s_ready = 1'b1;
        PRESENT: s_ready = win_ready;
        default: s_ready = 1'b0;
      endcase
    end
    accept_s  = s_valid & s_ready;
    consume_s = (state_r == PRESENT) & win_ready;
  end

  // Next-state, fill count and shift/sequence strobes; flush overrides all
  always_comb begin
    state_nxt_s    = state_r;
    fill_cnt_nxt_s = fill_cnt_r;
    shift_en_s     = 1'b0;
    seq_inc_s      = 1'b0;
    if (flush) begin
      state_nxt_s    = FILL;
      fill_cnt_nxt_s = 4'd0;
    end else begin
      case (state_r)
        FILL: begin
          if (accept_s) begin
            shift_en_s = 1'b1;
            if (fill_cnt_r == (FILL_FULL - 4'd1)) begin
              fill_cnt_nxt_s = FILL_FULL;
              state_nxt_s    = PRESENT;
            end else begin
              fill_cnt_nxt_s = fill_cnt_r + 4'd1;
            end
          end else begin
            fill_cnt_nxt_s = fill_cnt_r;
          end
        end
        PRESENT: begin
          if (consume_s) begin
            seq_inc_s = 1'b1;
            if (accept_s) begin
              shift_en_s     = 1'b1;
              fill_cnt_nxt_s = REFILL_PLUS1;
              state_nxt_s    = (REFILL_PLUS1 == FILL_FULL) ? PRESENT : FILL;
            end else begin
              fill_cnt_nxt_s = REFILL;
              state_nxt_s    = FILL;
            end
          end else begin
            state_nxt_s = PRESENT;
          end
        end
        default: begin
          state_nxt_s    = FILL;
          fill_cnt_nxt_s = 4'd0;
        end
      endcase
    end
  end

  // State, fill counter and window sequence registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FILL;
      fill_cnt_r <= 4'd0;
      win_seq_r  <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      fill_cnt_r <= fill_cnt_nxt_s;
      if (seq_inc_s) begin
        win_seq_r <= win_seq_r + 8'd1;
      end else begin
        win_seq_r <= win_seq_r;
      end
    end
  end

  assign win_valid = (state_r == PRESENT);
  assign win_seq   = win_seq_r;

  assign x0 = taps_s[0*DATA_W +: DATA_W];
  assign x1 = taps_s[1*DATA_W +: DATA_W];
  assign x2 = taps_s[2*DATA_W +: DATA_W];
  assign x3 = taps_s[3*DATA_W +: DATA_W];
  assign x4 = taps_s[4*DATA_W +: DATA_W];
  assign x5 = taps_s[5*DATA_W +: DATA_W];
  assign x6 = taps_s[6*DATA_W +: DATA_W];
  assign x7 = taps_s[7*DATA_W +: DATA_W];

endmodule
